// File: rtl/fft_out_streamer.sv
// Unloads FFT working memory in natural frequency order onto a valid/ready stream.
// A 2-entry skid FIFO absorbs the memory's 1-cycle read latency under backpressure.
module fft_out_streamer #(
    parameter int N_POINTS = 16,
    parameter int DATA_W   = 16,
    parameter bit BIT_REV  = 1'b1,
    parameter int ADDR_W   = $clog2(N_POINTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              done_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_re_i,
    input  logic [DATA_W-1:0] rd_im_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_re_o,
    output logic [DATA_W-1:0] m_im_o,
    output logic [ADDR_W-1:0] m_idx_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              stream_done_o,
    output logic              overrun_o,
    output logic [1:0]        state_o
);

    // Stream handshake: a sample transfers on a rising edge where m_valid_o & m_ready_i;
    // once raised, m_valid_o and the sample hold until that transfer, and m_valid_o
    // never depends combinationally on m_ready_i.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] rd_idx_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_idx_q;

    logic [1:0][DATA_W-1:0] fifo_re_q;
    logic [1:0][DATA_W-1:0] fifo_im_q;
    logic [1:0][ADDR_W-1:0] fifo_idx_q;
    logic [1:0]             fifo_last_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             fifo_cnt_q;

    logic overrun_q;
    logic stream_done_q;

    logic       push;
    logic       pop;
    logic [2:0] occupancy;
    logic       last_issue;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    assign push = inflight_q;
    assign pop  = m_valid_o & m_ready_i;

    // Occupancy the FIFO would reach if nothing new is issued; a read is only
    // issued when that leaves room for the returning sample.
    assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en_o    = (state_q == STREAM) && (occupancy < 3'd2);
    assign rd_addr_o  = BIT_REV ? bitrev(rd_idx_q) : rd_idx_q;
    assign last_issue = rd_en_o && (rd_idx_q == LAST_IDX);

    assign m_valid_o = (fifo_cnt_q != 2'd0);
    assign m_re_o    = m_valid_o ? fifo_re_q[rd_ptr_q]   : '0;
    assign m_im_o    = m_valid_o ? fifo_im_q[rd_ptr_q]   : '0;
    assign m_idx_o   = m_valid_o ? fifo_idx_q[rd_ptr_q]  : '0;
    assign m_last_o  = m_valid_o & fifo_last_q[rd_ptr_q];

    assign busy_o        = (state_q != IDLE);
    assign stream_done_o = stream_done_q;
    assign overrun_o     = overrun_q;
    assign state_o       = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (done_i)              state_d = STREAM;
            STREAM:  if (last_issue)          state_d = DRAIN;
            DRAIN:   if (pop && m_last_o)     state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            rd_idx_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            overrun_q      <= 1'b0;
            stream_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en_o;
            if (state_q == IDLE && done_i) begin
                rd_idx_q <= '0;
            end else if (rd_en_o) begin
                rd_idx_q <= rd_idx_q + ADDR_W'(1);
            end
            if (rd_en_o) begin
                inflight_idx_q <= rd_idx_q;
            end
            overrun_q     <= done_i && (state_q != IDLE);
            stream_done_q <= pop && m_last_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_re_q   <= '0;
            fifo_im_q   <= '0;
            fifo_idx_q  <= '0;
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_re_q[wr_ptr_q]   <= rd_re_i;
                fifo_im_q[wr_ptr_q]   <= rd_im_i;
                fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
                fifo_last_q[wr_ptr_q] <= (inflight_idx_q == LAST_IDX);
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
